i2c_target_sync: RTL and testbench

Oversampled, fully synchronous I2C target (slave) with parametrised register-file depth, glitch filtering and per-register strobes. It samples SCL/SDA in the FPGA clock domain rather than clocking logic from the bus lines, and exposes byte registers to rover fabric logic. It replaces bus-clocked I2C slaves wherever an on-board controller reads or writes FPGA control/status bytes.

---
 rtl/i2c_target_sync_pkg.sv | 26 ++
 rtl/i2c_line_filter.sv | 46 ++++
 rtl/i2c_target_sync.sv | 182 ++++++++++++++++++
 tb/tb_i2c_target_sync.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_sync_pkg.sv
// Shared types for the oversampled I2C target: byte bus type, FSM states and
// index-width helper used to address the register files.
package i2c_target_sync_pkg;

  typedef logic [7:0] bus08_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    WAIT
  } i2c_tgt_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one I2C pad line,
// with single-cycle pulses marking accepted rising and falling edges.
module i2c_line_filter
  import i2c_target_sync_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [3:0]             cnt;

  // Idle bus is high, so reset everything to 1 to avoid a fake edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[SYNC_STAGES-1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync[SYNC_STAGES-1];
        cnt   <= '0;
        rise  <= sync[SYNC_STAGES-1];
        fall  <= ~sync[SYNC_STAGES-1];
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_sync.sv
// Fabric-clocked I2C target exposing writable and readable byte registers
// through an auto-incrementing 8-bit pointer.
module i2c_target_sync
  import i2c_target_sync_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h55,
  parameter int         NUM_WR      = 16,
  parameter int         NUM_RD      = 16,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   sda_oe,
  input  bus08_t [NUM_RD-1:0]    rd_data,
  output bus08_t [NUM_WR-1:0]    wr_data,
  output logic   [NUM_WR-1:0]    wr_strobe,
  output logic   [NUM_RD-1:0]    rd_strobe,
  output logic                   busy
);

  localparam int WR_AW = idx_width(NUM_WR);
  localparam int RD_AW = idx_width(NUM_RD);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .rst   (rst),
    .pad   (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .rst   (rst),
    .pad   (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  i2c_tgt_state_t state;
  logic [7:0]     shreg;
  logic [7:0]     txreg;
  logic [7:0]     ptr;
  logic [2:0]     bit_cnt;
  logic           byte_done;
  logic           rw;
  logic           wr_ok, rd_ok, shifting;
  bus08_t         rd_byte;

  assign wr_ok    = int'(ptr) < NUM_WR;
  assign rd_ok    = int'(ptr) < NUM_RD;
  assign shifting = (state == ADDR) || (state == PTR) || (state == WR) || (state == RD);

  // Out-of-range read pointers return an all-ones byte (released bus).
  always_comb begin
    rd_byte = 8'hFF;
    if (rd_ok) rd_byte = rd_data[ptr[RD_AW-1:0]];
  end

  // Bits are captured on SCL rise; every SDA drive change waits for the following SCL fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_data   <= '0;
      wr_strobe <= '0;
      rd_strobe <= '0;
      shreg     <= '0;
      txreg     <= '0;
      ptr       <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
    end else begin
      wr_strobe <= '0;
      rd_strobe <= '0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else begin
        if (scl_rise && shifting) begin
          shreg   <= {shreg[6:0], sda};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done <= 1'b1;
        end
        case (state)
          ADDR: if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            if (shreg[7:1] == DEVICE_ADDR) begin
              state  <= ADDR_ACK;
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= shreg[0];
            end else begin
              state <= WAIT;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (rw) begin
              txreg  <= rd_byte;
              sda_oe <= ~rd_byte[7];
              if (rd_ok) rd_strobe[ptr[RD_AW-1:0]] <= 1'b1;
              ptr    <= ptr + 8'd1;
              state  <= RD;
            end else begin
              sda_oe <= 1'b0;
              state  <= PTR;
            end
          end
          PTR: if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            ptr       <= shreg;
            sda_oe    <= 1'b1;
            state     <= PTR_ACK;
          end
          PTR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= WR;
          end
          WR: if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            if (wr_ok) begin
              wr_data[ptr[WR_AW-1:0]]   <= shreg;
              wr_strobe[ptr[WR_AW-1:0]] <= 1'b1;
              sda_oe                    <= 1'b1;
            end
            ptr   <= ptr + 8'd1;
            state <= WR_ACK;
          end
          WR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= WR;
          end
          RD: if (scl_fall) begin
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b0;
              state     <= RD_ACK;
            end else begin
              txreg  <= {txreg[6:0], 1'b0};
              sda_oe <= ~txreg[6];
            end
          end
          // A master NACK ends the read; an ACK reloads on the following SCL fall.
          RD_ACK: begin
            if (scl_rise && sda) begin
              state <= WAIT;
            end else if (scl_fall) begin
              txreg  <= rd_byte;
              sda_oe <= ~rd_byte[7];
              if (rd_ok) rd_strobe[ptr[RD_AW-1:0]] <= 1'b1;
              ptr    <= ptr + 8'd1;
              state  <= RD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_sync.sv
// Scoreboard bench for i2c_target_sync: a bit-banged master drives the bus,
// expectations are queued up front and monitors compare as the DUT responds.
module tb_i2c_target_sync;
  import i2c_target_sync_pkg::*;

  localparam int NUM_WR = 16;
  localparam int NUM_RD = 16;
  localparam int Q      = 10;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m, sda_line;
  logic sda_oe, busy;
  bus08_t [NUM_RD-1:0] rd_data;
  bus08_t [NUM_WR-1:0] wr_data;
  bus08_t [NUM_WR-1:0] model;
  logic   [NUM_WR-1:0] wr_strobe;
  logic   [NUM_RD-1:0] rd_strobe;

  int checks = 0;
  int errors = 0;
  int bus_n  = 0;
  logic watch_idle = 1'b0;
  logic bad_seen   = 1'b0;

  wr_exp_t exp_wr[$];
  int      exp_rd[$];
  int      exp_bus[$];
  int      obs_bus[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_sync #(
    .DEVICE_ADDR (7'h55),
    .NUM_WR      (NUM_WR),
    .NUM_RD      (NUM_RD),
    .FILTER_LEN  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .rd_data   (rd_data),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0;
    wait_clk(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_restart();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(2*Q); sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  // glitch_pos selects a bit (7..0) that gets a one-clock SDA inversion while SCL is high.
  task automatic write_byte(input logic [7:0] b, input int glitch_pos);
    logic ack;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); sda_m = b[i];
      wait_clk(Q); scl_m = 1'b1;
      if (i == glitch_pos) begin
        wait_clk(2); sda_m = ~b[i];
        wait_clk(1); sda_m = b[i];
        wait_clk(Q-3);
      end else begin
        wait_clk(Q);
      end
      wait_clk(Q); scl_m = 1'b0;
    end
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); ack = sda_line;
    wait_clk(Q); scl_m = 1'b0;
    obs_bus.push_back(int'(ack));
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); sda_m = 1'b1;
      wait_clk(Q); scl_m = 1'b1;
      wait_clk(Q); d[i] = sda_line;
      wait_clk(Q); scl_m = 1'b0;
    end
    wait_clk(Q); sda_m = nack;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(2*Q); scl_m = 1'b0;
    obs_bus.push_back(int'(d));
  endtask

  // Full write transaction to 0x55; nack_mask marks data bytes the target must refuse.
  task automatic applyStimulus(input logic [7:0] ptr, input logic [7:0] d[4], input int n,
                               input logic [3:0] nack_mask, input int g_ptr, input int g_data);
    wr_exp_t e;
    exp_bus.push_back(0);
    exp_bus.push_back(0);
    for (int k = 0; k < n; k++) begin
      exp_bus.push_back(int'(nack_mask[k]));
      if (!nack_mask[k]) begin
        e.idx  = int'(ptr) + k;
        e.data = d[k];
        exp_wr.push_back(e);
        model[e.idx] = d[k];
      end
    end
    i2c_start();
    write_byte(8'hAA, -1);
    checkOutput("busy_addressed", busy, 1);
    write_byte(ptr, g_ptr);
    for (int k = 0; k < n; k++) write_byte(d[k], (k == 0) ? g_data : -1);
    i2c_stop();
    wait_clk(10);
    checkOutput("busy_after_stop", busy, 0);
    checkOutput("wr_data_regs", wr_data, model);
  endtask

  always @(negedge clk) begin
    wr_exp_t we;
    if (!rst && wr_strobe != '0) begin
      if (exp_wr.size() == 0) begin
        checkOutput("wr_strobe_unexpected", wr_strobe, 0);
      end else begin
        we = exp_wr.pop_front();
        checkOutput($sformatf("wr_strobe_%0d", we.idx), wr_strobe, 128'(1) << we.idx);
        checkOutput($sformatf("wr_data_%0d", we.idx), wr_data[we.idx], we.data);
      end
    end
  end

  always @(negedge clk) begin
    int ri;
    if (!rst && rd_strobe != '0) begin
      if (exp_rd.size() == 0) begin
        checkOutput("rd_strobe_unexpected", rd_strobe, 0);
      end else begin
        ri = exp_rd.pop_front();
        checkOutput($sformatf("rd_strobe_%0d", ri), rd_strobe, 128'(1) << ri);
      end
    end
  end

  always @(negedge clk) begin
    int ob, ex;
    if (obs_bus.size() > 0) begin
      ob = obs_bus.pop_front();
      bus_n++;
      if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL bus_extra_%0d actual=%0h expected=none", bus_n, ob);
      end else begin
        ex = exp_bus.pop_front();
        checkOutput($sformatf("bus_%0d", bus_n), ob, ex);
      end
    end
  end

  always @(negedge clk) begin
    if (watch_idle && (sda_oe || busy)) bad_seen = 1'b1;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    model = '0;
    for (int i = 0; i < NUM_RD; i++) rd_data[i] = bus08_t'(((i + 15) % 16) * 16);
    wait_clk(3);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_wr_strobe", wr_strobe, 0);
    checkOutput("rst_rd_strobe", rd_strobe, 0);
    rst = 1'b0;
    wait_clk(10);

    $display("[TB] single write ptr 0x03 <- 0xA5");
    applyStimulus(8'h03, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1, 4'b0000, -1, -1);

    $display("[TB] burst write at 0x0E, third byte past end");
    applyStimulus(8'h0E, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 4'b0100, -1, -1);

    $display("[TB] pointer 0x02, repeated start, read three bytes");
    exp_bus.push_back(0);
    exp_bus.push_back(0);
    exp_bus.push_back(0);
    exp_bus.push_back(8'h10);
    exp_bus.push_back(8'h20);
    exp_bus.push_back(8'h30);
    exp_rd.push_back(2);
    exp_rd.push_back(3);
    exp_rd.push_back(4);
    i2c_start();
    write_byte(8'hAA, -1);
    write_byte(8'h02, -1);
    i2c_restart();
    write_byte(8'hAB, -1);
    read_byte(1'b0);
    read_byte(1'b0);
    read_byte(1'b1);
    checkOutput("rd_released_after_nack", sda_oe, 0);
    i2c_stop();
    wait_clk(10);
    checkOutput("rd_busy_after_stop", busy, 0);

    $display("[TB] foreign address 0x54");
    bad_seen   = 1'b0;
    watch_idle = 1'b1;
    exp_bus.push_back(1);
    exp_bus.push_back(1);
    i2c_start();
    write_byte(8'hA8, -1);
    write_byte(8'h77, -1);
    i2c_stop();
    wait_clk(10);
    watch_idle = 1'b0;
    checkOutput("foreign_no_drive_no_busy", bad_seen, 0);
    checkOutput("foreign_wr_data", wr_data, model);

    $display("[TB] SDA glitches while SCL high");
    applyStimulus(8'h07, '{8'h3C, 8'h00, 8'h00, 8'h00}, 1, 4'b0000, 7, 5);

    $display("[TB] reset during read byte");
    exp_bus.push_back(0);
    exp_rd.push_back(8);
    i2c_start();
    write_byte(8'hAB, -1);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q);
    checkOutput("rd_bit7_driven", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_sda_oe", sda_oe, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_wr_data", wr_data, 0);
    wait_clk(2);
    rst   = 1'b0;
    model = '0;
    wait_clk(Q); scl_m = 1'b0;
    i2c_stop();
    wait_clk(10);
    checkOutput("postrst_wr_data", wr_data, 0);

    $display("[TB] write after reset, pointer 0x01");
    applyStimulus(8'h01, '{8'h5A, 8'h6B, 8'h00, 8'h00}, 2, 4'b0000, -1, -1);

    wait_clk(20);
    checkOutput("exp_wr_drained", exp_wr.size(), 0);
    checkOutput("exp_rd_drained", exp_rd.size(), 0);
    checkOutput("exp_bus_drained", exp_bus.size(), 0);
    checkOutput("final_wr_data", wr_data, model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
